life_render: RTL and testbench
==============================

Name: life_render

Overview:
- Downstream neighbour of the next-state pipeline; consumes its per-pixel alive bit and the delayed raster timing.
- Produces VGA RGB with board colouring, a blinking cursor crosshair and a border.
- Counts live cells every frame and publishes the population once per frame to the HUD/debug path.

Parameters:
- BLINK_LOG, 5, cursor blink half-period is 2^(BLINK_LOG-1) frames; blink state is frame_cnt[BLINK_LOG-1].
- GRID_STEP_LOG, 4, grid pitch is 2^GRID_STEP_LOG pixels; only used with LIFE_RENDER_GRID_EN.

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  synchronous, active-low reset; 0 on a rising edge resets
- hcount_in  in  HCOUNT_WIDTH  pixel x, aligned with alive_in
- vcount_in  in  VCOUNT_WIDTH  pixel y, aligned with alive_in
- hsync_in, vsync_in, blank_in  in  1 each  raster timing, aligned with alive_in
- alive_in  in  1  cell state for the current pixel; already 0 outside the board
- cursor_x_in, cursor_y_in  in  LOG_BOARD_SIZE  cursor cell
- hsync_out, vsync_out, blank_out  out  1 each  timing delayed 2 cycles
- rgb_out  out  12  {R[3:0],G[3:0],B[3:0]}
- population_out  out  2*LOG_BOARD_SIZE+1  live-cell count of the last full frame
- pop_valid_out  out  1  one-cycle pulse when population_out updates

Behaviour:
- Latency: exactly 2 cycles from the inputs to rgb_out and the sync/blank outputs. No stalls; one pixel per cycle.
- Reset (rst_in==0): rgb_out=0; hsync_out, vsync_out and blank_out all 1 (sync inactive-high idle, blanked); population_out=0; pop_valid_out=0; accumulator=0; frame_cnt=0; all pipeline registers cleared.
- Stage 1 registers the following:
  - in_board = hcount<BOARD_SIZE && vcount<BOARD_SIZE.
  - on_cursor = in_board && (hcount==cursor_x || vcount==cursor_y). This is a crosshair spanning the whole board.
  - on_border = (hcount==BOARD_SIZE && vcount<=BOARD_SIZE) || (vcount==BOARD_SIZE && hcount<=BOARD_SIZE).
  - alive, sync and blank are registered along with these.
- Stage 2 selects the colour by priority:
  1. blank → 0
  2. on_cursor && blink_on → CURSOR_COLOR
  3. in_board && alive → ALIVE_COLOR
  4. in_board → DEAD_COLOR
  5. on_border → BORDER_COLOR
  6. otherwise 0
- Population:
  - Accumulator increments on cycles where stage 1 has in_board && alive && !blank.
  - Frame end is the stage-1 cycle with vcount==BOARD_SIZE && hcount==0. On that cycle:
    - population_out takes the accumulator value;
    - pop_valid_out pulses one cycle later with population_out;
    - the accumulator clears;
    - frame_cnt increments, wrapping modulo 2^BLINK_LOG.
  - Because frame end lies outside the board, it never coincides with an increment.
- Width: the count saturates nowhere; BOARD_SIZE^2 fits in 2*LOG_BOARD_SIZE+1 bits.
- Mid-frame reset: the first frame end after reset publishes a partial count. This is allowed and documented.
- Cursor inputs are sampled every cycle; a cursor move mid-frame tears for one frame only.

Optional Feature:
- Macro: LIFE_RENDER_GRID_EN.
- Defined: dead in-board pixels with hcount[GRID_STEP_LOG-1:0]==0 or vcount[GRID_STEP_LOG-1:0]==0 show GRID_COLOR. Priority is between ALIVE_COLOR and DEAD_COLOR. Latency is unchanged.
- Undefined: no grid logic is present, and GRID_STEP_LOG is ignored.

Decomposition:
- Shared package gets:
  - typedef rgb_t (logic[11:0]);
  - typedef pop_t (logic[2*LOG_BOARD_SIZE:0]);
  - constants ALIVE_COLOR=12'hFFF, DEAD_COLOR=12'h000, CURSOR_COLOR=12'hF00, BORDER_COLOR=12'h0F0, GRID_COLOR=12'h222.
- BOARD_SIZE, LOG_BOARD_SIZE, HCOUNT_WIDTH and VCOUNT_WIDTH are already in the package.
- Sub-module: life_pop_counter, containing the accumulator, frame-end latch, pop_valid pulse and frame_cnt. It exports blink_on.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles → rgb_out=0, hsync_out/vsync_out/blank_out=1, population_out=0, pop_valid_out=0.
- Latency: alive_in=1 at (h=5, v=7), cursor at (100, 100) → rgb_out=12'hFFF exactly 2 cycles later, and hsync_out equals hsync_in delayed by 2.
- Cursor blink: cursor (10, 20), all dead, frame_cnt bit BLINK_LOG-1 set → pixels (10, any v<BOARD_SIZE) and (any h, 20) are 12'hF00. After 16 more frames they are 12'h000.
- Population: frame with exactly 3 alive pixels, (0,0), (BOARD_SIZE-1,BOARD_SIZE-1) and (5,5) → population_out=3 and pop_valid_out high for exactly one cycle. Next frame with 0 alive → 0.
- Blank/border: blank_in=1 with alive_in=1 → 0 and no count. Pixel (BOARD_SIZE, 3) unblanked → 12'h0F0. Pixel (BOARD_SIZE+1, 3) → 0.
- Grid (LIFE_RENDER_GRID_EN defined): dead pixel (16, 3) → 12'h222, dead (17, 3) → 12'h000, alive (16, 3) → 12'hFFF.

Source files
------------

// File: rtl/life_render_pkg.sv
// life_render_pkg
// Shared types and constants for the Life renderer slice.
//   - Board geometry (BOARD_SIZE, LOG_BOARD_SIZE) and raster counter widths.
//   - rgb_t : 12-bit {R[3:0],G[3:0],B[3:0]} pixel colour.
//   - pop_t : live-cell count; BOARD_SIZE^2 fits without saturation.
//   - Palette constants used by the colour selector.
package life_render_pkg;

    localparam int LOG_BOARD_SIZE = 7;
    localparam int BOARD_SIZE     = 1 << LOG_BOARD_SIZE;
    localparam int HCOUNT_WIDTH   = 10;
    localparam int VCOUNT_WIDTH   = 10;

    typedef logic [11:0]               rgb_t;
    typedef logic [2*LOG_BOARD_SIZE:0] pop_t;

    localparam rgb_t ALIVE_COLOR  = 12'hFFF;
    localparam rgb_t DEAD_COLOR   = 12'h000;
    localparam rgb_t CURSOR_COLOR = 12'hF00;
    localparam rgb_t BORDER_COLOR = 12'h0F0;
    localparam rgb_t GRID_COLOR   = 12'h222;

endpackage

// File: rtl/life_render_if.sv
// life_render_if
// Bundles the renderer's pixel-stream inputs and its video/HUD outputs.
//   master : upstream side (drives raster position, timing, alive bit, cursor;
//            receives rgb, delayed timing and population).
//   slave  : the renderer itself.
interface life_render_if;
    import life_render_pkg::*;

    logic [HCOUNT_WIDTH-1:0]   hcount_in;
    logic [VCOUNT_WIDTH-1:0]   vcount_in;
    logic                      hsync_in;
    logic                      vsync_in;
    logic                      blank_in;
    logic                      alive_in;
    logic [LOG_BOARD_SIZE-1:0] cursor_x_in;
    logic [LOG_BOARD_SIZE-1:0] cursor_y_in;

    logic                      hsync_out;
    logic                      vsync_out;
    logic                      blank_out;
    rgb_t                      rgb_out;
    pop_t                      population_out;
    logic                      pop_valid_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, blank_in, alive_in,
               cursor_x_in, cursor_y_in,
        input  hsync_out, vsync_out, blank_out, rgb_out, population_out, pop_valid_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, blank_in, alive_in,
               cursor_x_in, cursor_y_in,
        output hsync_out, vsync_out, blank_out, rgb_out, population_out, pop_valid_out
    );

endinterface

// File: rtl/life_pop_counter.sv
// life_pop_counter
// Counts live, visible board pixels over a frame and publishes the total at
// frame end; also keeps the frame counter that drives the cursor blink.
//   clk_in, rst_in : pixel clock, synchronous active-low reset
//   count_en       : stage-1 pixel is in board, alive and unblanked
//   frame_end      : stage-1 pixel is the frame-end marker (h=0, v=BOARD_SIZE)
//   population     : count of the last completed frame
//   pop_valid      : one-cycle pulse, aligned with a population update
//   blink_on       : frame_cnt[BLINK_LOG-1]
module life_pop_counter
    import life_render_pkg::*;
#(
    parameter int BLINK_LOG = 5
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic count_en,
    input  logic frame_end,
    output pop_t population,
    output logic pop_valid,
    output logic blink_on
);

    pop_t                 acc_reg, acc_next;
    pop_t                 pop_reg, pop_next;
    logic                 pop_valid_reg;
    logic [BLINK_LOG-1:0] frame_cnt_reg, frame_cnt_next;

    // Frame end sits outside the board, so clearing and counting never collide.
    always_comb begin
        acc_next       = acc_reg;
        pop_next       = pop_reg;
        frame_cnt_next = frame_cnt_reg;
        if (frame_end) begin
            pop_next       = acc_reg;
            acc_next       = '0;
            frame_cnt_next = frame_cnt_reg + 1'b1;
        end else if (count_en) begin
            acc_next = acc_reg + pop_t'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            acc_reg       <= '0;
            pop_reg       <= '0;
            pop_valid_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            acc_reg       <= acc_next;
            pop_reg       <= pop_next;
            pop_valid_reg <= frame_end;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign population = pop_reg;
    assign pop_valid  = pop_valid_reg;
    assign blink_on   = frame_cnt_reg[BLINK_LOG-1];

endmodule

// File: rtl/life_render.sv
// life_render
// Two-stage pixel renderer: board colouring, blinking cursor crosshair, border,
// plus a per-frame live-cell population count.
//   clk_in : pixel clock
//   rst_in : synchronous active-low reset
//   bus    : life_render_if.slave (raster in, alive bit, cursor; rgb, delayed
//            sync/blank, population_out/pop_valid_out)
// Latency is 2 cycles for rgb and timing; one pixel per cycle, no stalls.
// Optional macro LIFE_RENDER_GRID_EN: dead board pixels on every
// 2^GRID_STEP_LOG-th row/column show GRID_COLOR. The GRID_STEP_LOG parameter
// only exists when the macro is defined.
module life_render
    import life_render_pkg::*;
#(
    parameter int BLINK_LOG = 5
`ifdef LIFE_RENDER_GRID_EN
    , parameter int GRID_STEP_LOG = 4
`endif
) (
    input  logic          clk_in,
    input  logic          rst_in,
    life_render_if.slave  bus
);

    localparam logic [HCOUNT_WIDTH-1:0] H_EDGE = HCOUNT_WIDTH'(BOARD_SIZE);
    localparam logic [VCOUNT_WIDTH-1:0] V_EDGE = VCOUNT_WIDTH'(BOARD_SIZE);

    // Stage-1 decode
    logic in_board_next, on_cursor_next, on_border_next, frame_end_next;
    logic in_board_reg, on_cursor_reg, on_border_reg, frame_end_reg, alive_reg;
    logic hsync_s1_reg, vsync_s1_reg, blank_s1_reg;
`ifdef LIFE_RENDER_GRID_EN
    logic on_grid_next, on_grid_reg;
`endif

    // Stage-2 outputs
    rgb_t rgb_next, rgb_reg;
    logic hsync_s2_reg, vsync_s2_reg, blank_s2_reg;

    logic blink_on;
    logic count_en;

    always_comb begin
        in_board_next  = (bus.hcount_in < H_EDGE) && (bus.vcount_in < V_EDGE);
        on_cursor_next = in_board_next &&
                         ((bus.hcount_in == HCOUNT_WIDTH'(bus.cursor_x_in)) ||
                          (bus.vcount_in == VCOUNT_WIDTH'(bus.cursor_y_in)));
        on_border_next = ((bus.hcount_in == H_EDGE) && (bus.vcount_in <= V_EDGE)) ||
                         ((bus.vcount_in == V_EDGE) && (bus.hcount_in <= H_EDGE));
        frame_end_next = (bus.vcount_in == V_EDGE) && (bus.hcount_in == '0);
`ifdef LIFE_RENDER_GRID_EN
        on_grid_next   = in_board_next &&
                         ((bus.hcount_in[GRID_STEP_LOG-1:0] == '0) ||
                          (bus.vcount_in[GRID_STEP_LOG-1:0] == '0));
`endif
    end

    // Stage-1 timing resets to the idle level (syncs high, blanked) so the
    // outputs do not glitch active for a cycle as reset releases.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            in_board_reg  <= 1'b0;
            on_cursor_reg <= 1'b0;
            on_border_reg <= 1'b0;
            frame_end_reg <= 1'b0;
            alive_reg     <= 1'b0;
            hsync_s1_reg  <= 1'b1;
            vsync_s1_reg  <= 1'b1;
            blank_s1_reg  <= 1'b1;
`ifdef LIFE_RENDER_GRID_EN
            on_grid_reg   <= 1'b0;
`endif
        end else begin
            in_board_reg  <= in_board_next;
            on_cursor_reg <= on_cursor_next;
            on_border_reg <= on_border_next;
            frame_end_reg <= frame_end_next;
            alive_reg     <= bus.alive_in;
            hsync_s1_reg  <= bus.hsync_in;
            vsync_s1_reg  <= bus.vsync_in;
            blank_s1_reg  <= bus.blank_in;
`ifdef LIFE_RENDER_GRID_EN
            on_grid_reg   <= on_grid_next;
`endif
        end
    end

    // Colour priority: blank, cursor (when lit), alive, grid, dead, border.
    always_comb begin
        rgb_next = '0;
        if (blank_s1_reg)
            rgb_next = '0;
        else if (on_cursor_reg && blink_on)
            rgb_next = CURSOR_COLOR;
        else if (in_board_reg && alive_reg)
            rgb_next = ALIVE_COLOR;
`ifdef LIFE_RENDER_GRID_EN
        else if (on_grid_reg)
            rgb_next = GRID_COLOR;
`endif
        else if (in_board_reg)
            rgb_next = DEAD_COLOR;
        else if (on_border_reg)
            rgb_next = BORDER_COLOR;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rgb_reg      <= '0;
            hsync_s2_reg <= 1'b1;
            vsync_s2_reg <= 1'b1;
            blank_s2_reg <= 1'b1;
        end else begin
            rgb_reg      <= rgb_next;
            hsync_s2_reg <= hsync_s1_reg;
            vsync_s2_reg <= vsync_s1_reg;
            blank_s2_reg <= blank_s1_reg;
        end
    end

    assign count_en = in_board_reg && alive_reg && !blank_s1_reg;

    life_pop_counter #(
        .BLINK_LOG (BLINK_LOG)
    ) u_pop_counter (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .count_en   (count_en),
        .frame_end  (frame_end_reg),
        .population (bus.population_out),
        .pop_valid  (bus.pop_valid_out),
        .blink_on   (blink_on)
    );

    assign bus.rgb_out   = rgb_reg;
    assign bus.hsync_out = hsync_s2_reg;
    assign bus.vsync_out = vsync_s2_reg;
    assign bus.blank_out = blank_s2_reg;

endmodule

// File: tb/tb_life_render.sv
// tb_life_render
// Directed testbench for life_render. Pixels are driven one per clock; the
// renderer's view of a pixel appears two edges later, so after driving pixel
// P and one further pixel, rgb_out/timing reflect P. A "frame" is simply the
// pixels of interest followed by the frame-end pixel (h=0, v=BOARD_SIZE).
module tb_life_render;
    import life_render_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    life_render_if bus();

    life_render dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int errors   = 0;
    int checks   = 0;
    int fe_count = 0;

    task automatic drive(input int h, input int v, input logic a, input logic bl,
                         input logic hs, input logic vs);
        bus.hcount_in = HCOUNT_WIDTH'(h);
        bus.vcount_in = VCOUNT_WIDTH'(v);
        bus.alive_in  = a;
        bus.blank_in  = bl;
        bus.hsync_in  = hs;
        bus.vsync_in  = vs;
        @(posedge clk_in);
        #1;
        $display("pix h=%0d v=%0d alive=%0b blank=%0b hs=%0b | rgb=%h hs=%0b vs=%0b bl=%0b pop=%0d pv=%0b",
                 h, v, a, bl, hs, bus.rgb_out, bus.hsync_out, bus.vsync_out,
                 bus.blank_out, bus.population_out, bus.pop_valid_out);
    endtask

    task automatic idle();
        drive(600, 400, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic frame_end();
        drive(0, BOARD_SIZE, 1'b0, 1'b0, 1'b1, 1'b1);
        fe_count++;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) drive(5, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", bus.rgb_out); end
        checks++; if (bus.hsync_out !== 1'b1) begin errors++; $display("FAIL reset_hsync got=%b exp=1", bus.hsync_out); end
        checks++; if (bus.vsync_out !== 1'b1) begin errors++; $display("FAIL reset_vsync got=%b exp=1", bus.vsync_out); end
        checks++; if (bus.blank_out !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", bus.blank_out); end
        checks++; if (bus.population_out !== pop_t'(0)) begin errors++; $display("FAIL reset_pop got=%0d exp=0", bus.population_out); end
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL reset_pv got=%b exp=0", bus.pop_valid_out); end
        rst_in = 1'b1;
        idle();
        idle();
    endtask

    task automatic test_latency();
        drive(5, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.rgb_out !== 12'h000) begin errors++; $display("FAIL lat_rgb_early got=%h exp=000", bus.rgb_out); end
        checks++; if (bus.hsync_out !== 1'b1) begin errors++; $display("FAIL lat_hsync_early got=%b exp=1", bus.hsync_out); end
        idle();
        checks++; if (bus.rgb_out !== 12'hFFF) begin errors++; $display("FAIL lat_rgb got=%h exp=fff", bus.rgb_out); end
        checks++; if (bus.hsync_out !== 1'b0) begin errors++; $display("FAIL lat_hsync got=%b exp=0", bus.hsync_out); end
        checks++; if (bus.vsync_out !== 1'b0) begin errors++; $display("FAIL lat_vsync got=%b exp=0", bus.vsync_out); end
        checks++; if (bus.blank_out !== 1'b0) begin errors++; $display("FAIL lat_blank got=%b exp=0", bus.blank_out); end
        idle();
        checks++; if (bus.hsync_out !== 1'b1) begin errors++; $display("FAIL lat_hsync_after got=%b exp=1", bus.hsync_out); end
    endtask

    task automatic test_population();
        // Flush: the one alive pixel from the latency test is the partial count.
        frame_end();
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL pop_flush_pv_early got=%b exp=0", bus.pop_valid_out); end
        idle();
        checks++; if (bus.pop_valid_out !== 1'b1) begin errors++; $display("FAIL pop_flush_pv got=%b exp=1", bus.pop_valid_out); end
        checks++; if (bus.population_out !== pop_t'(1)) begin errors++; $display("FAIL pop_flush got=%0d exp=1", bus.population_out); end
        idle();
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL pop_flush_pv_late got=%b exp=0", bus.pop_valid_out); end
        checks++; if (bus.population_out !== pop_t'(1)) begin errors++; $display("FAIL pop_flush_hold got=%0d exp=1", bus.population_out); end

        drive(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(BOARD_SIZE-1, BOARD_SIZE-1, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(5, 5, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (bus.rgb_out !== 12'hFFF) begin errors++; $display("FAIL pop_corner_rgb got=%h exp=fff", bus.rgb_out); end
        drive(50, 50, 1'b0, 1'b0, 1'b1, 1'b1);
        frame_end();
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL pop3_pv_early got=%b exp=0", bus.pop_valid_out); end
        idle();
        checks++; if (bus.population_out !== pop_t'(3)) begin errors++; $display("FAIL pop3 got=%0d exp=3", bus.population_out); end
        checks++; if (bus.pop_valid_out !== 1'b1) begin errors++; $display("FAIL pop3_pv got=%b exp=1", bus.pop_valid_out); end
        idle();
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL pop3_pv_late got=%b exp=0", bus.pop_valid_out); end

        drive(20, 30, 1'b0, 1'b0, 1'b1, 1'b1);
        frame_end();
        idle();
        checks++; if (bus.population_out !== pop_t'(0)) begin errors++; $display("FAIL pop0 got=%0d exp=0", bus.population_out); end
        checks++; if (bus.pop_valid_out !== 1'b1) begin errors++; $display("FAIL pop0_pv got=%b exp=1", bus.pop_valid_out); end
    endtask

    task automatic test_blank_border();
        drive(10, 10, 1'b1, 1'b1, 1'b1, 1'b1);
        idle();
        checks++; if (bus.rgb_out !== 12'h000) begin errors++; $display("FAIL blank_rgb got=%h exp=000", bus.rgb_out); end
        checks++; if (bus.blank_out !== 1'b1) begin errors++; $display("FAIL blank_out got=%b exp=1", bus.blank_out); end
        drive(BOARD_SIZE, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        checks++; if (bus.rgb_out !== 12'h0F0) begin errors++; $display("FAIL border_rgb got=%h exp=0f0", bus.rgb_out); end
        drive(BOARD_SIZE+1, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        checks++; if (bus.rgb_out !== 12'h000) begin errors++; $display("FAIL outside_rgb got=%h exp=000", bus.rgb_out); end
        drive(BOARD_SIZE, BOARD_SIZE, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        checks++; if (bus.rgb_out !== 12'h0F0) begin errors++; $display("FAIL border_corner got=%h exp=0f0", bus.rgb_out); end
        frame_end();
        idle();
        checks++; if (bus.population_out !== pop_t'(0)) begin errors++; $display("FAIL blank_nocount got=%0d exp=0", bus.population_out); end
    endtask

    task automatic test_cursor_blink();
        int   ph [6] = '{10, 77, 10, 10, 11, 10};
        int   pv [6] = '{50, 20, 20, BOARD_SIZE-1, 21, BOARD_SIZE};
        logic pa [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rgb_t on_exp  [6] = '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h000, 12'h0F0};
        rgb_t off_exp [6] = '{12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h0F0};
        bus.cursor_x_in = LOG_BOARD_SIZE'(10);
        bus.cursor_y_in = LOG_BOARD_SIZE'(20);
        // Bring frame_cnt to 16: blink bit set.
        repeat (16 - fe_count) frame_end();
        idle();
        idle();
        for (int i = 0; i < 6; i++) begin
            drive(ph[i], pv[i], pa[i], 1'b0, 1'b1, 1'b1);
            idle();
            checks++;
            if (bus.rgb_out !== on_exp[i]) begin
                errors++;
                $display("FAIL blink_on_%0d got=%h exp=%h", i, bus.rgb_out, on_exp[i]);
            end
        end
        // 16 frames later frame_cnt wraps to 0: cursor hidden.
        repeat (16) frame_end();
        idle();
        idle();
        for (int i = 0; i < 6; i++) begin
            drive(ph[i], pv[i], pa[i], 1'b0, 1'b1, 1'b1);
            idle();
            checks++;
            if (bus.rgb_out !== off_exp[i]) begin
                errors++;
                $display("FAIL blink_off_%0d got=%h exp=%h", i, bus.rgb_out, off_exp[i]);
            end
        end
    endtask

    task automatic test_grid();
`ifdef LIFE_RENDER_GRID_EN
        drive(16, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        checks++; if (bus.rgb_out !== 12'h222) begin errors++; $display("FAIL grid_dead got=%h exp=222", bus.rgb_out); end
        drive(17, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        checks++; if (bus.rgb_out !== 12'h000) begin errors++; $display("FAIL grid_off got=%h exp=000", bus.rgb_out); end
        drive(16, 3, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
        checks++; if (bus.rgb_out !== 12'hFFF) begin errors++; $display("FAIL grid_alive got=%h exp=fff", bus.rgb_out); end
`else
        drive(16, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        checks++; if (bus.rgb_out !== 12'h000) begin errors++; $display("FAIL nogrid_dead got=%h exp=000", bus.rgb_out); end
`endif
    endtask

    task automatic test_back_to_back();
        int   bh [4] = '{1, 2, 3, BOARD_SIZE};
        logic ba [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rgb_t be [4] = '{12'hFFF, 12'h000, 12'hFFF, 12'h0F0};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(bh[i], 1, ba[i], 1'b0, 1'b1, 1'b1);
            else       idle();
            if (i >= 1) begin
                checks++;
                if (bus.rgb_out !== be[i-1]) begin
                    errors++;
                    $display("FAIL b2b_%0d got=%h exp=%h", i-1, bus.rgb_out, be[i-1]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.hcount_in   = '0;
        bus.vcount_in   = '0;
        bus.hsync_in    = 1'b1;
        bus.vsync_in    = 1'b1;
        bus.blank_in    = 1'b1;
        bus.alive_in    = 1'b0;
        bus.cursor_x_in = LOG_BOARD_SIZE'(100);
        bus.cursor_y_in = LOG_BOARD_SIZE'(100);
        test_reset();
        test_latency();
        test_population();
        test_blank_border();
        test_cursor_blink();
        test_grid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
